// File: rtl/machine_log_buffer_pkg.sv
// Shared types for the machine log buffer: operator codes and the packed
// log record produced by the purchase, charge and change-price stages.
package machine_log_buffer_pkg;

    typedef enum logic [1:0] {
        LOG_BUY          = 2'b00,
        LOG_CHARGE       = 2'b01,
        LOG_RESTOCK      = 2'b10,
        LOG_CHANGE_PRICE = 2'b11
    } log_op_e;

    // Field order matches the readout word {operator, status, product, value}.
    typedef struct packed {
        log_op_e    op;
        logic       status;   // 1 = success, 0 = rejected
        logic [2:0] product;
        logic [3:0] value;    // price, item count or coin
    } log_record_t;

    localparam int NUM_PRODUCTS = 5;
    localparam int REC_W        = $bits(log_record_t);

endpackage

// File: rtl/machine_log_buffer_if.sv
// Producer and readout signals of the log buffer. The master side is the
// producer/maintenance logic; the slave side is the buffer itself.
interface machine_log_buffer_if #(
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 8,
    parameter int DROP_W = 8
);
    import machine_log_buffer_pkg::*;

    // Producer side
    logic                     clear;
    logic                     log_valid;
    log_op_e                  log_operator;
    logic                     log_param1;
    logic [2:0]               log_param2;
    logic [3:0]               log_param3;
    logic                     log_ready;

    // Readout side
    logic                     rd_req;
    logic                     rd_valid;
    log_record_t              rd_record;
    logic [SEQ_W-1:0]         rd_seq;

    // Status
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     empty;
    logic [DROP_W-1:0]        drop_count;

    modport master (
        output clear, log_valid, log_operator, log_param1, log_param2, log_param3, rd_req,
        input  log_ready, rd_valid, rd_record, rd_seq, count, full, empty, drop_count
    );

    modport slave (
        input  clear, log_valid, log_operator, log_param1, log_param2, log_param3, rd_req,
        output log_ready, rd_valid, rd_record, rd_seq, count, full, empty, drop_count
    );

endinterface

// File: rtl/machine_log_buffer_log_fifo_mem.sv
// Storage for the log buffer: a DEPTH x WIDTH register array with one write
// port and a registered read port. Pointer management lives in the parent.
module log_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port: store the stamped record at the write address.
    // NOTE: the array itself is not reset; stale contents are never read because
    // the parent only reads slots it has written since the last reset or clear.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: capture the addressed slot; holds its value between reads.
    // NOTE: non-blocking assignment here means a read and a write to the same
    // slot in one cycle returns the old contents, which the full-buffer
    // read-plus-write case relies on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/machine_log_buffer.sv
// Circular log buffer: stamps each incoming record with a sequence number,
// stores it in FIFO order, and drains one record per readout request.
// Producers never stall; records arriving while full are dropped and counted.
module machine_log_buffer #(
    parameter int DEPTH  = 16,
    parameter int SEQ_W  = 8,
    parameter int DROP_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    machine_log_buffer_if.slave  bus
);
    import machine_log_buffer_pkg::*;

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int WORD_W = REC_W + SEQ_W;

    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    // Control decodes; clear overrides both ports.
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_drop;
    log_record_t       w_rec;
    logic [WORD_W-1:0] w_wdata;
    logic [WORD_W-1:0] w_rdata;
    logic [CW-1:0]     w_count_nxt;

    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic [SEQ_W-1:0]  r_seq;
    logic [DROP_W-1:0] r_drop;
    logic              r_rd_valid;

    // A read in the same cycle frees a slot, so a full buffer still accepts.
    assign w_wr_en = bus.log_valid && (!r_full || bus.rd_req) && !bus.clear;
    assign w_drop  = bus.log_valid && r_full && !bus.rd_req && !bus.clear;
    // Reads look only at the registered empty flag: no write-through.
    assign w_rd_en = bus.rd_req && !r_empty && !bus.clear;

    assign w_rec   = {bus.log_operator, bus.log_param1, bus.log_param2, bus.log_param3};
    assign w_wdata = {w_rec, r_seq};

    // Next occupancy: a simultaneous read and write leaves it unchanged.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_en && !w_rd_en) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_en && w_rd_en) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Pointers, occupancy and status flags, updated together so they always agree.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else if (bus.clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Sequence stamp: advances for every offered record, stored or dropped,
    // so gaps in the readout reveal losses. Clear freezes it for that cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seq <= '0;
        end else if (bus.log_valid && !bus.clear) begin
            r_seq <= r_seq + SEQ_W'(1);
        end
    end

    // Overflow counter: saturates rather than wrapping; cleared by flush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drop <= '0;
        end else if (bus.clear) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != DROP_MAX)) begin
            r_drop <= r_drop + DROP_W'(1);
        end
    end

    // Readout strobe: one pulse per accepted pop, aligned with the memory output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
        end
    end

    log_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr_en (w_wr_en),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_rd_en (w_rd_en),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign bus.log_ready  = !r_full;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_record  = log_record_t'(w_rdata[WORD_W-1:SEQ_W]);
    assign bus.rd_seq     = w_rdata[SEQ_W-1:0];
    assign bus.count      = r_count;
    assign bus.full       = r_full;
    assign bus.empty      = r_empty;
    assign bus.drop_count = r_drop;

endmodule

// File: tb/tb_machine_log_buffer.sv
// Self-checking bench for machine_log_buffer: directed scenarios followed by a
// random phase, all compared against a queue-based reference model.
module tb_machine_log_buffer;
    import machine_log_buffer_pkg::*;

    localparam int DEPTH  = 16;
    localparam int SEQ_W  = 8;
    localparam int DROP_W = 8;
    localparam int SEQ_MOD  = 1 << SEQ_W;
    localparam int DROP_SAT = (1 << DROP_W) - 1;

    typedef struct packed {
        log_record_t      rec;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    logic clk;
    logic rst;

    machine_log_buffer_if #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) bus ();

    machine_log_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(DROP_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    entry_t           q[$];
    int               m_seq;
    int               m_drops;
    logic             m_rd_valid;
    log_record_t      m_rec;
    logic [SEQ_W-1:0] m_seqo;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq      = 0;
        m_drops    = 0;
        m_rd_valid = 1'b0;
        m_rec      = '0;
        m_seqo     = '0;
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".count"},     32'(bus.count),      32'(q.size()));
        check({ctx, ".full"},      32'(bus.full),       32'(q.size() == DEPTH));
        check({ctx, ".empty"},     32'(bus.empty),      32'(q.size() == 0));
        check({ctx, ".log_ready"}, 32'(bus.log_ready),  32'(q.size() != DEPTH));
        check({ctx, ".drops"},     32'(bus.drop_count), 32'(m_drops));
        check({ctx, ".rd_valid"},  32'(bus.rd_valid),   32'(m_rd_valid));
        check({ctx, ".rd_record"}, 32'(bus.rd_record),  32'(m_rec));
        check({ctx, ".rd_seq"},    32'(bus.rd_seq),     32'(m_seqo));
    endtask

    // One clock of stimulus: drive, predict, clock, then compare 1 time unit later.
    task automatic step(input bit v, input log_record_t r, input bit rq, input bit clr, input string ctx);
        int     sz;
        entry_t e;
        bus.log_valid    = v;
        bus.log_operator = r.op;
        bus.log_param1   = r.status;
        bus.log_param2   = r.product;
        bus.log_param3   = r.value;
        bus.rd_req       = rq;
        bus.clear        = clr;
        sz         = q.size();
        m_rd_valid = 1'b0;
        if (clr) begin
            q.delete();
            m_drops = 0;
        end else begin
            if (rq && sz > 0) begin
                e          = q.pop_front();
                m_rec      = e.rec;
                m_seqo     = e.seq;
                m_rd_valid = 1'b1;
            end
            if (v) begin
                if (sz < DEPTH || rq) begin
                    e.rec = r;
                    e.seq = SEQ_W'(m_seq);
                    q.push_back(e);
                end else if (m_drops < DROP_SAT) begin
                    m_drops++;
                end
                m_seq = (m_seq + 1) % SEQ_MOD;
            end
        end
        @(posedge clk);
        #1;
        bus.log_valid = 1'b0;
        bus.rd_req    = 1'b0;
        bus.clear     = 1'b0;
        check_outputs(ctx);
    endtask

    task automatic apply_reset(input string ctx);
        rst           = 1'b1;
        bus.log_valid = 1'b0;
        bus.rd_req    = 1'b0;
        bus.clear     = 1'b0;
        #1;
        model_reset();
        check_outputs(ctx);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic log_record_t rand_rec();
        logic [31:0] rr;
        rr = $urandom();
        return log_record_t'(rr[REC_W-1:0]);
    endfunction

    function automatic log_record_t val_rec(input int v);
        log_record_t r;
        r = rand_rec();
        r.value = 4'(v);
        return r;
    endfunction

    initial begin
        log_record_t r;
        log_record_t zero_rec;
        logic [31:0] rr;
        n_checks = 0;
        n_fail   = 0;
        zero_rec = '0;
        bus.log_operator = LOG_BUY;
        bus.log_param1   = 1'b0;
        bus.log_param2   = '0;
        bus.log_param3   = '0;
        apply_reset("reset");

        // 1. Single record round trip.
        r = 10'b11_1_010_0111;
        step(1'b1, r, 1'b0, 1'b0, "t1.write");
        step(1'b0, zero_rec, 1'b1, 1'b0, "t1.read");
        check("t1.rd_valid_1",   32'(bus.rd_valid),  32'd1);
        check("t1.rd_record_lit", 32'(bus.rd_record), 32'(10'b11_1_010_0111));
        check("t1.rd_seq_0",     32'(bus.rd_seq),    32'd0);
        check("t1.empty_1",      32'(bus.empty),     32'd1);
        step(1'b0, zero_rec, 1'b0, 1'b0, "t1.hold");

        // 2. Fill past capacity, drain, verify the stamp gap.
        apply_reset("t2.reset");
        for (int i = 0; i < 18; i++) step(1'b1, val_rec(i), 1'b0, 1'b0, "t2.fill");
        check("t2.full",  32'(bus.full),       32'd1);
        check("t2.drops", 32'(bus.drop_count), 32'd2);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, zero_rec, 1'b1, 1'b0, "t2.drain");
            check("t2.drain_seq",   32'(bus.rd_seq),          32'(i));
            check("t2.drain_value", 32'(bus.rd_record.value), 32'(i));
        end
        step(1'b0, zero_rec, 1'b1, 1'b0, "t2.read_empty");
        step(1'b1, rand_rec(), 1'b0, 1'b0, "t2.write_after");
        step(1'b0, zero_rec, 1'b1, 1'b0, "t2.read_after");
        check("t2.seq_18", 32'(bus.rd_seq), 32'd18);

        // 3. Full buffer with simultaneous write and read.
        apply_reset("t3.reset");
        for (int i = 0; i < 16; i++) step(1'b1, val_rec(i), 1'b0, 1'b0, "t3.fill");
        step(1'b1, rand_rec(), 1'b1, 1'b0, "t3.rw_full");
        check("t3.count_16", 32'(bus.count),      32'd16);
        check("t3.drops_0",  32'(bus.drop_count), 32'd0);
        check("t3.rd_seq_0", 32'(bus.rd_seq),     32'd0);

        // 4. Empty buffer with simultaneous write and read: no write-through.
        apply_reset("t4.reset");
        r = rand_rec();
        step(1'b1, r, 1'b1, 1'b0, "t4.rw_empty");
        check("t4.no_valid", 32'(bus.rd_valid), 32'd0);
        check("t4.count_1",  32'(bus.count),    32'd1);
        step(1'b0, zero_rec, 1'b1, 1'b0, "t4.read");
        check("t4.rec", 32'(bus.rd_record), 32'(r));

        // 5. Drop-counter saturation, then flush.
        apply_reset("t5.reset");
        for (int i = 0; i < 260; i++) step(1'b1, rand_rec(), 1'b0, 1'b0, "t5.flood");
        check("t5.drops_244", 32'(bus.drop_count), 32'd244);
        for (int i = 0; i < 20; i++) step(1'b1, rand_rec(), 1'b0, 1'b0, "t5.flood2");
        check("t5.drops_sat", 32'(bus.drop_count), 32'd255);
        step(1'b1, rand_rec(), 1'b1, 1'b1, "t5.clear");
        check("t5.count_0",  32'(bus.count),      32'd0);
        check("t5.drops_0",  32'(bus.drop_count), 32'd0);
        check("t5.empty",    32'(bus.empty),      32'd1);
        check("t5.no_valid", 32'(bus.rd_valid),   32'd0);
        step(1'b1, rand_rec(), 1'b0, 1'b0, "t5.write");
        step(1'b0, zero_rec, 1'b1, 1'b0, "t5.read");
        check("t5.seq_24", 32'(bus.rd_seq), 32'd24);

        // 6. Asynchronous reset in the middle of a read burst.
        apply_reset("t6.reset");
        for (int i = 0; i < 6; i++) step(1'b1, rand_rec(), 1'b0, 1'b0, "t6.fill");
        step(1'b0, zero_rec, 1'b1, 1'b0, "t6.pop");
        check("t6.count_5", 32'(bus.count), 32'd5);
        bus.rd_req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("t6.async");
        @(posedge clk);
        #1;
        check("t6.valid_in_rst", 32'(bus.rd_valid), 32'd0);
        check_outputs("t6.held");
        rst        = 1'b0;
        bus.rd_req = 1'b0;
        step(1'b1, rand_rec(), 1'b0, 1'b0, "t6.write");
        step(1'b0, zero_rec, 1'b1, 1'b0, "t6.read");
        check("t6.seq_0", 32'(bus.rd_seq), 32'd0);

        // Random phase against the model.
        apply_reset("rand.reset");
        for (int i = 0; i < 1500; i++) begin
            rr = $urandom_range(99, 0);
            step(($urandom_range(99, 0) < 55), rand_rec(), ($urandom_range(99, 0) < 40),
                 (rr < 2), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
